// File: rtl/angle_color_unit.sv
// Registered helper for the shape editor: angle wrap stepping, quarter-wave ROM cosine,
// and a 128x128 RGB colour-picker palette with crosshair rendering. One cycle latency.
module angle_color_unit #(
    parameter int INTW     = 16,
    parameter int FRACW    = 16,
    parameter int DW_BOUND = -180,
    parameter int UP_BOUND = 179,
    parameter int PIXLW    = 12,
    parameter int PSIZE    = 128
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [INTW-1:0]         angle_in,
    output logic signed [INTW-1:0]         angle_prev,
    output logic signed [INTW-1:0]         angle_next,
    output logic signed [INTW+FRACW-1:0]   cos_out,
    input  logic        [INTW-1:0]         cur_x,
    input  logic        [INTW-1:0]         cur_y,
    input  logic        [INTW-1:0]         px_x,
    input  logic        [INTW-1:0]         px_y,
    output logic        [PIXLW-1:0]        color,
    output logic        [PIXLW-1:0]        render
);

    localparam int EW = INTW + 1;

    // round(cos(k deg) * 2^16) for k = 0..90
    function automatic logic [16:0] cos_rom(input logic [6:0] k);
        logic [16:0] r;
        case (k)
            7'd0:  r = 17'd65536; 7'd1:  r = 17'd65526; 7'd2:  r = 17'd65496; 7'd3:  r = 17'd65446;
            7'd4:  r = 17'd65376; 7'd5:  r = 17'd65287; 7'd6:  r = 17'd65177; 7'd7:  r = 17'd65048;
            7'd8:  r = 17'd64898; 7'd9:  r = 17'd64729; 7'd10: r = 17'd64540; 7'd11: r = 17'd64332;
            7'd12: r = 17'd64104; 7'd13: r = 17'd63856; 7'd14: r = 17'd63589; 7'd15: r = 17'd63303;
            7'd16: r = 17'd62997; 7'd17: r = 17'd62672; 7'd18: r = 17'd62328; 7'd19: r = 17'd61966;
            7'd20: r = 17'd61584; 7'd21: r = 17'd61183; 7'd22: r = 17'd60764; 7'd23: r = 17'd60326;
            7'd24: r = 17'd59870; 7'd25: r = 17'd59396; 7'd26: r = 17'd58903; 7'd27: r = 17'd58393;
            7'd28: r = 17'd57865; 7'd29: r = 17'd57319; 7'd30: r = 17'd56756; 7'd31: r = 17'd56175;
            7'd32: r = 17'd55578; 7'd33: r = 17'd54963; 7'd34: r = 17'd54332; 7'd35: r = 17'd53684;
            7'd36: r = 17'd53020; 7'd37: r = 17'd52339; 7'd38: r = 17'd51643; 7'd39: r = 17'd50931;
            7'd40: r = 17'd50203; 7'd41: r = 17'd49461; 7'd42: r = 17'd48703; 7'd43: r = 17'd47930;
            7'd44: r = 17'd47143; 7'd45: r = 17'd46341; 7'd46: r = 17'd45525; 7'd47: r = 17'd44695;
            7'd48: r = 17'd43852; 7'd49: r = 17'd42995; 7'd50: r = 17'd42126; 7'd51: r = 17'd41243;
            7'd52: r = 17'd40348; 7'd53: r = 17'd39441; 7'd54: r = 17'd38521; 7'd55: r = 17'd37590;
            7'd56: r = 17'd36647; 7'd57: r = 17'd35693; 7'd58: r = 17'd34729; 7'd59: r = 17'd33754;
            7'd60: r = 17'd32768; 7'd61: r = 17'd31772; 7'd62: r = 17'd30767; 7'd63: r = 17'd29753;
            7'd64: r = 17'd28729; 7'd65: r = 17'd27697; 7'd66: r = 17'd26656; 7'd67: r = 17'd25607;
            7'd68: r = 17'd24550; 7'd69: r = 17'd23486; 7'd70: r = 17'd22415; 7'd71: r = 17'd21336;
            7'd72: r = 17'd20252; 7'd73: r = 17'd19161; 7'd74: r = 17'd18064; 7'd75: r = 17'd16962;
            7'd76: r = 17'd15855; 7'd77: r = 17'd14742; 7'd78: r = 17'd13626; 7'd79: r = 17'd12505;
            7'd80: r = 17'd11380; 7'd81: r = 17'd10252; 7'd82: r = 17'd9121;  7'd83: r = 17'd7987;
            7'd84: r = 17'd6850;  7'd85: r = 17'd5712;  7'd86: r = 17'd4572;  7'd87: r = 17'd3430;
            7'd88: r = 17'd2287;  7'd89: r = 17'd1144;
            default: r = 17'd0;
        endcase
        return r;
    endfunction

    function automatic logic [11:0] pal(input logic [6:0] u, input logic [6:0] v);
        logic [7:0] b;
        b = 8'd254 - {1'b0, u} - {1'b0, v};
        return {u[6:3], v[6:3], b[7:4]};
    endfunction

    logic signed [INTW-1:0]       prev_d, prev_q, next_d, next_q;
    logic signed [INTW+FRACW-1:0] cos_d, cos_q, cos_mag;
    logic        [PIXLW-1:0]      color_d, color_q, render_d, render_q;
    logic signed [INTW:0]         ext, red;
    logic        [INTW:0]         mag;
    logic        [6:0]            idx, sx, sy;
    logic                         flip;

    always_comb begin
        prev_d = (angle_in == INTW'(DW_BOUND)) ? INTW'(UP_BOUND) : angle_in - INTW'(1);
        next_d = (angle_in == INTW'(UP_BOUND)) ? INTW'(DW_BOUND) : angle_in + INTW'(1);

        // Reduce to [-180,179], then fold onto the 0..90 quarter wave
        ext = EW'(angle_in);
        red = ext % EW'(360);
        if (red >= EW'(180)) begin
            red = red - EW'(360);
        end else if (red < -EW'(180)) begin
            red = red + EW'(360);
        end
        mag     = red[INTW] ? -red : red;
        flip    = (mag > EW'(90));
        idx     = flip ? 7'(EW'(180) - mag) : mag[6:0];
        cos_mag = (INTW+FRACW)'(cos_rom(idx));
        cos_d   = flip ? -cos_mag : cos_mag;

        sx      = (cur_x >= INTW'(PSIZE)) ? 7'(PSIZE - 1) : cur_x[6:0];
        sy      = (cur_y >= INTW'(PSIZE)) ? 7'(PSIZE - 1) : cur_y[6:0];
        color_d = pal(sx, sy);
        if (px_x >= INTW'(PSIZE) || px_y >= INTW'(PSIZE)) begin
            render_d = '0;
        end else if (px_x[6:0] == sx || px_y[6:0] == sy) begin
            render_d = ~pal(px_x[6:0], px_y[6:0]);
        end else begin
            render_d = pal(px_x[6:0], px_y[6:0]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q   <= '0;
            next_q   <= '0;
            cos_q    <= '0;
            color_q  <= '0;
            render_q <= '0;
        end else begin
            prev_q   <= prev_d;
            next_q   <= next_d;
            cos_q    <= cos_d;
            color_q  <= color_d;
            render_q <= render_d;
        end
    end

    assign angle_prev = prev_q;
    assign angle_next = next_q;
    assign cos_out    = cos_q;
    assign color      = color_q;
    assign render     = render_q;

endmodule

// File: tb/tb_angle_color_unit.sv
// Bench for angle_color_unit: constant vector table, real-valued cosine sweep and a
// randomized back-to-back stream with a mid-stream reset pulse, all via a scoreboard queue.
module tb_angle_color_unit;

    typedef struct {
        logic signed [15:0] ang;
        logic        [15:0] cx, cy, px, py;
        logic signed [15:0] e_prev, e_next;
        logic signed [31:0] e_cos;
        logic        [11:0] e_col, e_ren;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic signed [15:0] angle_in = '0;
    logic signed [15:0] angle_prev, angle_next;
    logic signed [31:0] cos_out;
    logic        [15:0] cur_x = '0, cur_y = '0, px_x = '0, px_y = '0;
    logic        [11:0] color, render;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t sb[$];
    vec_t tbl[13];

    angle_color_unit dut (
        .clk        (clk),
        .rst        (rst),
        .angle_in   (angle_in),
        .angle_prev (angle_prev),
        .angle_next (angle_next),
        .cos_out    (cos_out),
        .cur_x      (cur_x),
        .cur_y      (cur_y),
        .px_x       (px_x),
        .px_y       (px_y),
        .color      (color),
        .render     (render)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int a, input int cx, input int cy, input int px,
                                input int py, input int ep, input int en, input int ec,
                                input int ecol, input int eren);
        vec_t v;
        v.ang = 16'(a); v.cx = 16'(cx); v.cy = 16'(cy); v.px = 16'(px); v.py = 16'(py);
        v.e_prev = 16'(ep); v.e_next = 16'(en); v.e_cos = ec;
        v.e_col = 12'(ecol); v.e_ren = 12'(eren);
        return v;
    endfunction

    function automatic int pal(input int u, input int v);
        return ((u >> 3) << 8) | ((v >> 3) << 4) | ((254 - u - v) >> 4);
    endfunction

    function automatic vec_t model(input int a, input int cx, input int cy, input int px,
                                   input int py);
        int r, sx, sy, ren;
        real c;
        r = ((a % 360) + 360) % 360;
        if (r >= 180) r = r - 360;
        c = $cos(real'(r) * 3.14159265358979323846 / 180.0) * 65536.0;
        sx = (cx >= 128) ? 127 : cx;
        sy = (cy >= 128) ? 127 : cy;
        if (px >= 128 || py >= 128) ren = 0;
        else if (px == sx || py == sy) ren = (~pal(px, py)) & 12'hFFF;
        else ren = pal(px, py);
        return mk(a, cx, cy, px, py, (a == -180) ? 179 : a - 1, (a == 179) ? -180 : a + 1,
                  int'(c), pal(sx, sy), ren);
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_prev"}, angle_prev, 0);
        chk({tag, "_next"}, angle_next, 0);
        chk({tag, "_cos"}, cos_out, 0);
        chk({tag, "_color"}, color, 0);
        chk({tag, "_render"}, render, 0);
    endtask

    // Drive at the falling edge, compare one rising edge later.
    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        angle_in = v.ang; cur_x = v.cx; cur_y = v.cy; px_x = v.px; px_y = v.py;
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_prev"}, angle_prev, e.e_prev);
            chk({tag, "_next"}, angle_next, e.e_next);
            chk({tag, "_cos"}, cos_out, e.e_cos);
            chk({tag, "_color"}, color, e.e_col);
            chk({tag, "_render"}, render, e.e_ren);
        end
    endtask

    initial begin
        tbl[0]  = mk(0, 0, 0, 0, 0, -1, 1, 65536, 12'h00F, 12'hFF0);
        tbl[1]  = mk(-180, 127, 127, 5, 5, 179, -179, -65536, 12'hFF0, 12'h00F);
        tbl[2]  = mk(179, 64, 32, 128, 5, 178, -180, -65526, 12'h849, 12'h000);
        tbl[3]  = mk(37, 300, 5, 127, 0, 36, 38, 52339, 12'hF07, 12'h0F8);
        tbl[4]  = mk(60, 10, 20, 10, 50, 59, 61, 32768, 12'h12E, 12'hE93);
        tbl[5]  = mk(90, 10, 20, 11, 21, 89, 91, 0, 12'h12E, 12'h12D);
        tbl[6]  = mk(-90, 10, 20, 128, 5, -91, -89, 0, 12'h12E, 12'h000);
        tbl[7]  = mk(-45, 0, 200, 3, 127, -46, -44, 46341, 12'h0F7, 12'hF08);
        tbl[8]  = mk(1, 50, 60, 40, 70, 0, 2, 65526, 12'h679, 12'h589);
        tbl[9]  = mk(135, 50, 60, 0, 200, 134, 136, -46341, 12'h679, 12'h000);
        tbl[10] = mk(360, 50, 60, 50, 0, 359, 361, 65536, 12'h679, 12'h9F3);
        tbl[11] = mk(180, 0, 0, 1, 1, 179, 181, -65536, 12'h00F, 12'h00F);
        tbl[12] = mk(-181, 0, 0, 0, 65535, -182, -180, -65526, 12'h00F, 12'h000);

        // Asynchronous reset with random inputs, checked before the first clock edge
        angle_in = 16'($urandom); cur_x = 16'($urandom); cur_y = 16'($urandom);
        px_x = 16'($urandom_range(0, 127)); px_y = 16'($urandom_range(0, 127));
        #1 rst = 1'b1;
        #1 check_zero("rst_async");
        @(posedge clk);
        #1 check_zero("rst_held");
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

        // Outputs must not follow a new input before the next edge
        @(negedge clk);
        angle_in = 16'sd0;
        #1 chk("latency_hold_prev", angle_prev, -182);
        @(posedge clk);
        #1 chk("latency_upd_prev", angle_prev, -1);

        for (int a = -180; a <= 179; a++) apply(model(a, 64, 64, 10, 10), $sformatf("sweep%0d", a));

        for (int i = 0; i < 50; i++) begin
            if (i == 25) begin
                @(negedge clk);
                rst = 1'b1;
                #1 check_zero("pulse_async");
                sb.delete();
                @(posedge clk);
                #1 check_zero("pulse_held");
                rst = 1'b0;
            end
            apply(model(int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 160)),
                        int'($urandom_range(0, 160)), int'($urandom_range(0, 160)),
                        int'($urandom_range(0, 160))), $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/angle_color_unit.md
Name: angle_color_unit

Overview:
- Registered helper block for the shape editor. It computes three things each cycle:
  - the wrap-around previous/next value of a shape angle in degrees;
  - the fixed-point cosine of that angle;
  - a 128x128 RGB colour-picker palette: the colour picked at the cursor and the pixel to render at a scan position.
- Sits between the core control FSM (angle rotation, colour selection) and the VGA pixel mux.

Parameters:
- INTW, 16, width of integer angle/coordinate inputs and angle outputs.
- FRACW, 16, fractional bits of the fixed-point cosine output.
- DW_BOUND, -180, lowest legal angle (inclusive).
- UP_BOUND, 179, highest legal angle (inclusive).
- PIXLW, 12, colour width, RGB 4:4:4 with R in [11:8], G in [7:4], B in [3:0].
- PSIZE, 128, palette edge length in pixels.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- angle_in  in  INTW signed  current angle in degrees.
- angle_prev  out  INTW signed  angle-1, with wrap.
- angle_next  out  INTW signed  angle+1, with wrap.
- cos_out  out  INTW+FRACW signed  cos(angle_in) in Q(INTW).FRACW format.
- cur_x  in  INTW unsigned  picker cursor column.
- cur_y  in  INTW unsigned  picker cursor row.
- px_x  in  INTW unsigned  scan pixel column, relative to the palette origin.
- px_y  in  INTW unsigned  scan pixel row, relative to the palette origin.
- color  out  PIXLW  palette colour at the cursor.
- render  out  PIXLW  pixel colour to draw at (px_x, px_y).

Behaviour:
- All outputs are registered. Latency is exactly 1 clock from inputs to outputs; a new result is produced every cycle.
- Asynchronous reset (rst=1): all outputs go to 0 immediately and are held at 0 while rst=1. Normal operation starts on the first rising edge after rst falls. Asserting rst mid-operation discards pending results.
- Angle step:
  - angle_prev = UP_BOUND if angle_in == DW_BOUND, else angle_in-1.
  - angle_next = DW_BOUND if angle_in == UP_BOUND, else angle_in+1.
  - Out-of-range inputs are not wrapped; plain ±1 is applied.
- Cosine:
  - The input is first reduced modulo 360 into [-180,179], so 180 → -180 and 360 → 0.
  - cos_out = round(cos(deg)·2^FRACW), rounding half away from zero.
  - Implemented as a 91-entry quarter-wave ROM (0..90°) with symmetry: cos(-a)=cos(a), cos(180-a)=-cos(a).
  - Exact endpoints: 0° → +65536, ±90° → 0, -180° → -65536. Results are symmetric in sign.
- Palette function P(u,v), for u,v in 0..PSIZE-1:
  - R = u>>3
  - G = v>>3
  - B = (254-u-v)>>4
  - Result is the concatenation {R,G,B}.
- color:
  - Cursor coordinates are saturated to PSIZE-1 (any value ≥128 acts as 127).
  - color = P(sat(cur_x), sat(cur_y)).
- render:
  - If px_x ≥ PSIZE or px_y ≥ PSIZE: 12'h000.
  - Else, if px_x == sat(cur_x) or px_y == sat(cur_y): bitwise inverse ~P(px_x,px_y), which draws a crosshair.
  - Otherwise: P(px_x,px_y).
- The three sub-functions are independent; simultaneous input changes never interact.

Test Plan:
- Reset: hold rst=1 with random inputs → all outputs 0 asynchronously, before any clock edge. Release rst and clock once with angle_in=0 → angle_prev=-1, angle_next=1, cos_out=65536.
- Angle wrap: angle_in=-180 → prev=179, next=-179. angle_in=179 → prev=178, next=-180. angle_in=37 → prev=36, next=38. Each result appears one cycle after the input.
- Cosine values:
  - 60 → 32768
  - 90 → 0
  - -90 → 0
  - -180 → -65536
  - -45 → 46341
  - 1 → 65526
  - 135 → -46341
  - 360 → 65536 (modulo reduction)
  - Sweep -180..179 and check against a real-valued model, within ±0 LSB after rounding.
- Cursor colour: (cur_x,cur_y)=(0,0) → 12'h00F. (127,127) → 12'hFF0. (64,32) → R=8, G=4, B=9, i.e. 12'h849. (300,5) saturates to (127,5) → 12'hF07.
- Render crosshair: cursor (10,20), px=(10,50) → ~P(10,50)=~12'h16C=12'hE93. px=(11,21) → P(11,21)=12'h12D. px=(128,5) → 12'h000.
- Pipelining: change all inputs every cycle for 50 cycles → each output equals the model applied to the previous cycle's inputs, with no bubbles. Pulse rst for one cycle mid-stream → outputs 0 during the pulse, then resume.
